// File: rtl/coeff_token_enc02_if.sv
// Request/bitstream bundle for coeff_token_enc02.
// Optional macro COEFF_TOKEN_ENC02_CHECK_EN adds the sticky err flag.
interface coeff_token_enc02_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] total_coeff;
  logic [1:0] trailing_ones;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready;
  logic       bit_last;
  logic [4:0] code_len;
`ifdef COEFF_TOKEN_ENC02_CHECK_EN
  logic       err;

  modport master (
    output in_valid, total_coeff, trailing_ones, bit_ready,
    input  in_ready, bit_out, bit_valid, bit_last, code_len, err
  );
  modport slave (
    input  in_valid, total_coeff, trailing_ones, bit_ready,
    output in_ready, bit_out, bit_valid, bit_last, code_len, err
  );
`else
  modport master (
    output in_valid, total_coeff, trailing_ones, bit_ready,
    input  in_ready, bit_out, bit_valid, bit_last, code_len
  );
  modport slave (
    input  in_valid, total_coeff, trailing_ones, bit_ready,
    output in_ready, bit_out, bit_valid, bit_last, code_len
  );
`endif
endinterface

// File: rtl/coeff_token_enc02.sv
// H.264 coeff_token encoder (Table 9-5, 0<=nC<2), serialised MSB first.
// Macro COEFF_TOKEN_ENC02_CHECK_EN: reject illegal requests and raise sticky err.
module coeff_token_enc02 (
  input  logic               clk,
  input  logic               rst,
  coeff_token_enc02_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]  state;
  logic [15:0] code_q;
  logic [4:0]  cnt_q;
  logic [4:0]  len_q;
  logic [6:0]  sel;
  logic [20:0] ent;
  logic [4:0]  lut_len;
  logic [15:0] lut_code;
  logic        shifting;
  logic        last;
  logic        accept;
  logic        consume;
  logic        load;

  assign sel = {bus.total_coeff, bus.trailing_ones};

  // {len, right-aligned value}; index is TotalCoeff*4+TrailingOnes, illegal -> "1"
  always_comb begin
    ent = {5'd1, 16'd1};
    case (sel)
      7'd0:  ent = {5'd1,  16'd1};
      7'd4:  ent = {5'd6,  16'd5};  7'd5:  ent = {5'd2,  16'd1};
      7'd8:  ent = {5'd8,  16'd7};  7'd9:  ent = {5'd6,  16'd4};  7'd10: ent = {5'd3,  16'd1};
      7'd12: ent = {5'd9,  16'd7};  7'd13: ent = {5'd8,  16'd6};  7'd14: ent = {5'd7,  16'd5};  7'd15: ent = {5'd5,  16'd3};
      7'd16: ent = {5'd10, 16'd7};  7'd17: ent = {5'd9,  16'd6};  7'd18: ent = {5'd8,  16'd5};  7'd19: ent = {5'd6,  16'd3};
      7'd20: ent = {5'd11, 16'd7};  7'd21: ent = {5'd10, 16'd6};  7'd22: ent = {5'd9,  16'd5};  7'd23: ent = {5'd7,  16'd4};
      7'd24: ent = {5'd13, 16'd15}; 7'd25: ent = {5'd11, 16'd6};  7'd26: ent = {5'd10, 16'd5};  7'd27: ent = {5'd8,  16'd4};
      7'd28: ent = {5'd13, 16'd11}; 7'd29: ent = {5'd13, 16'd14}; 7'd30: ent = {5'd11, 16'd5};  7'd31: ent = {5'd9,  16'd4};
      7'd32: ent = {5'd13, 16'd8};  7'd33: ent = {5'd13, 16'd10}; 7'd34: ent = {5'd13, 16'd13}; 7'd35: ent = {5'd10, 16'd4};
      7'd36: ent = {5'd14, 16'd15}; 7'd37: ent = {5'd14, 16'd14}; 7'd38: ent = {5'd13, 16'd9};  7'd39: ent = {5'd11, 16'd4};
      7'd40: ent = {5'd14, 16'd11}; 7'd41: ent = {5'd14, 16'd10}; 7'd42: ent = {5'd14, 16'd13}; 7'd43: ent = {5'd13, 16'd12};
      7'd44: ent = {5'd15, 16'd15}; 7'd45: ent = {5'd15, 16'd14}; 7'd46: ent = {5'd14, 16'd9};  7'd47: ent = {5'd14, 16'd12};
      7'd48: ent = {5'd15, 16'd11}; 7'd49: ent = {5'd15, 16'd10}; 7'd50: ent = {5'd15, 16'd13}; 7'd51: ent = {5'd14, 16'd8};
      7'd52: ent = {5'd16, 16'd15}; 7'd53: ent = {5'd15, 16'd1};  7'd54: ent = {5'd15, 16'd9};  7'd55: ent = {5'd15, 16'd12};
      7'd56: ent = {5'd16, 16'd11}; 7'd57: ent = {5'd16, 16'd14}; 7'd58: ent = {5'd16, 16'd13}; 7'd59: ent = {5'd15, 16'd8};
      7'd60: ent = {5'd16, 16'd7};  7'd61: ent = {5'd16, 16'd10}; 7'd62: ent = {5'd16, 16'd9};  7'd63: ent = {5'd16, 16'd12};
      7'd64: ent = {5'd16, 16'd4};  7'd65: ent = {5'd16, 16'd6};  7'd66: ent = {5'd16, 16'd5};  7'd67: ent = {5'd16, 16'd8};
      default: ent = {5'd1, 16'd1};
    endcase
  end

  assign lut_len  = ent[20:16];
  assign lut_code = ent[15:0] << (5'd16 - lut_len);

  assign shifting = (state == SHIFT);
  assign last     = shifting && (cnt_q == 5'd1);
  assign consume  = shifting && bus.bit_ready;
  // next request may slip in on the final bit so the stream has no bubble
  assign bus.in_ready  = !shifting || (last && bus.bit_ready);
  assign bus.bit_valid = shifting;
  assign bus.bit_out   = shifting && code_q[15];
  assign bus.bit_last  = last;
  assign bus.code_len  = len_q;
  assign accept        = bus.in_valid && bus.in_ready;

`ifdef COEFF_TOKEN_ENC02_CHECK_EN
  logic legal;
  logic err_q;
  assign legal   = (bus.total_coeff <= 5'd16) && ({3'b000, bus.trailing_ones} <= bus.total_coeff);
  assign load    = accept && legal;
  assign bus.err = err_q;

  always_ff @(posedge clk) begin
    if (rst)                  err_q <= 1'b0;
    else if (accept && !legal) err_q <= 1'b1;
  end
`else
  assign load = accept;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      code_q <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
    end else if (load) begin
      state  <= SHIFT;
      code_q <= lut_code;
      cnt_q  <= lut_len;
      len_q  <= lut_len;
    end else if (consume) begin
      code_q <= {code_q[14:0], 1'b0};
      cnt_q  <= cnt_q - 5'd1;
      if (cnt_q == 5'd1) state <= IDLE;
    end
  end
endmodule
